card_dealer: RTL and testbench

//  Source end of the card interface of the bell game. The game logic judges the
//  two face-up cards against the keypad; this block produces those cards.
//  It deals pseudo-random card pairs (c1/n1, c2/n2) and drives the 8-bit

---
 rtl/game_pkg.sv | 19 +
 rtl/lfsr16.sv | 19 +
 rtl/card_dealer.sv | 118 +++++++++++
 tb/tb_card_dealer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Types and widths shared by the bell-game blocks (dealer, judge, score).
package game_pkg;
   localparam int COLOR_W = 2;
   localparam int NUM_W   = 3;
   localparam int SCORE_W = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DEAL = 3'd1,
      SHOW = 3'd2,
      GAP  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Folds a 3-bit random value onto card numbers 1..5.
   function automatic logic [NUM_W-1:0] card_num(input logic [2:0] x);
      return (x < 3'd5) ? x + 3'd1 : x - 3'd4;
   endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); reloads seed in reset, shifts otherwise.
module lfsr16 (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] q
);
   logic fb;

   assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= seed;
      end else begin
         q <= {fb, q[15:1]};
      end
   end
endmodule

// File: rtl/card_dealer.sv
// Deals pseudo-random card pairs, runs the decaying score countdown and
// sequences ROUNDS rounds separated by blank gaps.
module card_dealer
   import game_pkg::*;
#(
   parameter int                 TICK_DIV  = 25_000_000,
   parameter logic [SCORE_W-1:0] COUNT_MAX = 8'd9,
   parameter int                 GAP_CYC   = 12_500_000,
   parameter int                 ROUNDS    = 16,
   parameter logic [15:0]        SEED      = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               finish,
   output logic [COLOR_W-1:0] c1,
   output logic [COLOR_W-1:0] c2,
   output logic [NUM_W-1:0]   n1,
   output logic [NUM_W-1:0]   n2,
   output logic [SCORE_W-1:0] count,
   output logic               card_valid,
   output logic [7:0]         round,
   output logic               game_over
);
   localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
   localparam logic [7:0]  ROUND_END = 8'(ROUNDS);

   state_t      state;
   logic [15:0] lfsr_q;
   logic [31:0] timer;
   logic        fin_q;
   logic        fin_rise;
   logic        tick;
   logic        to_gap;
   logic        unused_bits;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (SEED),
      .q    (lfsr_q)
   );

   assign unused_bits = &{1'b0, lfsr_q[15:10]};
   assign fin_rise    = finish & ~fin_q;
   assign tick        = (timer == TICK_LAST);
   // A finish edge and a timeout on the same cycle both land in GAP once.
   assign to_gap      = (state == SHOW) && (fin_rise || (tick && count == 8'd1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         fin_q      <= 1'b0;
         timer      <= 32'd0;
         c1         <= '0;
         c2         <= '0;
         n1         <= '0;
         n2         <= '0;
         count      <= '0;
         card_valid <= 1'b0;
         round      <= 8'd0;
         game_over  <= 1'b0;
      end else begin
         fin_q <= finish;
         case (state)
            IDLE: begin
               if (start) state <= DEAL;
            end
            DEAL: begin
               n1         <= card_num(lfsr_q[2:0]);
               n2         <= card_num(lfsr_q[7:5]);
               c1         <= lfsr_q[4:3];
               c2         <= lfsr_q[9:8];
               count      <= COUNT_MAX;
               timer      <= 32'd0;
               card_valid <= 1'b1;
               if (round != ROUND_END) round <= round + 8'd1;
               state      <= SHOW;
            end
            SHOW: begin
               if (to_gap) begin
                  c1         <= '0;
                  c2         <= '0;
                  n1         <= '0;
                  n2         <= '0;
                  count      <= '0;
                  card_valid <= 1'b0;
                  timer      <= 32'd0;
                  state      <= GAP;
               end else if (tick) begin
                  timer <= 32'd0;
                  count <= count - 8'd1;
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            GAP: begin
               if (timer == GAP_LAST) begin
                  timer <= 32'd0;
                  if (round == ROUND_END) begin
                     state     <= DONE;
                     game_over <= 1'b1;
                  end else begin
                     state <= DEAL;
                  end
               end else begin
                  timer <= timer + 32'd1;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: stimulus queues expected output events,
// a negedge monitor pops and compares them as the outputs change.
module tb_card_dealer;
   import game_pkg::*;

   localparam int EV_SHOW  = 0;
   localparam int EV_COUNT = 1;
   localparam int EV_BLANK = 2;
   localparam int EV_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       finish = 1'b0;
   logic [1:0] c1, c2;
   logic [2:0] n1, n2;
   logic [7:0] count;
   logic       card_valid;
   logic [7:0] round;
   logic       game_over;

   card_dealer #(
      .TICK_DIV  (4),
      .COUNT_MAX (8'd3),
      .GAP_CYC   (2),
      .ROUNDS    (2),
      .SEED      (16'hACE1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .finish     (finish),
      .c1         (c1),
      .c2         (c2),
      .n1         (n1),
      .n2         (n2),
      .count      (count),
      .card_valid (card_valid),
      .round      (round),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   // Reference LFSR; hist[k] is the register value after the k-th posedge since reset.
   logic [15:0] m_lfsr;
   int          cyc = 0;
   logic [15:0] hist [0:4095];

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
   endfunction

   function automatic int exp_num(input logic [2:0] x);
      return (x < 3'd5) ? int'(x) + 1 : int'(x) - 4;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_lfsr  <= 16'hACE1;
         cyc     <= 0;
         hist[0] <= 16'hACE1;
      end else begin
         m_lfsr                  <= lfsr_next(m_lfsr);
         cyc                     <= cyc + 1;
         hist[(cyc + 1) & 4095]  <= lfsr_next(m_lfsr);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int kind, input int at, input int val);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // One full round ending by timeout: count 3 -> 2 -> 1 at 4-cycle spacing.
   task automatic push_timeout_round(input int t, input int rnd);
      push(EV_SHOW, t, rnd);
      push(EV_COUNT, t + 4, 2);
      push(EV_COUNT, t + 8, 1);
      push(EV_BLANK, t + 12, 0);
   endtask

   task automatic got_event(input int kind);
      ev_t         e;
      logic [15:0] d;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_event: got kind %0d at cyc %0d, required none", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         check("event_cyc", cyc, e.cyc);
         case (kind)
            EV_SHOW: begin
               d = hist[(cyc - 1) & 4095];
               check("show_round", int'(round), e.val);
               check("show_count", int'(count), 3);
               check("show_n1", int'(n1), exp_num(d[2:0]));
               check("show_n2", int'(n2), exp_num(d[7:5]));
               check("show_c1", int'(c1), int'(d[4:3]));
               check("show_c2", int'(c2), int'(d[9:8]));
            end
            EV_COUNT: check("count_step", int'(count), e.val);
            EV_BLANK: begin
               check("blank_count", int'(count), 0);
               check("blank_cards", int'({c1, c2, n1, n2}), 0);
            end
            default: check("done_blank", int'(card_valid), 0);
         endcase
      end
   endtask

   logic       p_valid = 1'b0;
   logic       p_go    = 1'b0;
   logic [7:0] p_count = 8'd0;

   always @(negedge clk) begin
      if (card_valid && !p_valid) got_event(EV_SHOW);
      else if (!card_valid && p_valid) got_event(EV_BLANK);
      else if (card_valid && count != p_count) got_event(EV_COUNT);
      if (game_over && !p_go) got_event(EV_DONE);
      p_valid <= card_valid;
      p_go    <= game_over;
      p_count <= count;
   end

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc < n) begin
         n_checks++;
         $display("FAIL wait_cyc: got cyc %0d, required %0d", cyc, n);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic check_drained(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      s = 3;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_outputs", int'({c1, c2, n1, n2, count, card_valid, round, game_over}), 0);
      check("rst_lfsr", int'(dut.u_lfsr.q), 16'hACE1);
      check("rst_state", int'(dut.state), int'(IDLE));
      rst = 1'b1;
      wait_cyc(1);
      check("lfsr_first_step", int'(dut.u_lfsr.q), 16'h5670);

      // Round 1 cut by a finish edge at count 2, round 2 times out, then DONE
      wait_cyc(s);
      start = 1'b1;
      push(EV_SHOW, s + 2, 1);
      push(EV_COUNT, s + 6, 2);
      push(EV_BLANK, s + 8, 0);
      push(EV_SHOW, s + 11, 2);
      push(EV_COUNT, s + 15, 2);
      push(EV_COUNT, s + 19, 1);
      push(EV_BLANK, s + 23, 0);
      push(EV_DONE, s + 25, 0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 7);
      finish = 1'b1;
      wait_cyc(s + 8);
      finish = 1'b0;
      wait_cyc(s + 26);
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         finish = i[0];
         @(negedge clk);
      end
      start  = 1'b0;
      finish = 1'b0;
      wait_cyc(s + 34);
      check("done_game_over", int'(game_over), 1);
      check("done_round", int'(round), 2);
      check("done_valid", int'(card_valid), 0);
      check_drained("drain_game1");

      // finish held high: only its first rising edge ends a round
      do_reset();
      wait_cyc(s);
      start = 1'b1;
      push(EV_SHOW, s + 2, 1);
      push(EV_BLANK, s + 4, 0);
      push_timeout_round(s + 7, 2);
      push(EV_DONE, s + 21, 0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 3);
      finish = 1'b1;
      wait_cyc(s + 23);
      finish = 1'b0;
      check_drained("drain_game2");

      // finish edge coincides with the timeout tick
      do_reset();
      wait_cyc(s);
      start = 1'b1;
      push_timeout_round(s + 2, 1);
      push_timeout_round(s + 17, 2);
      push(EV_DONE, s + 31, 0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 13);
      finish = 1'b1;
      wait_cyc(s + 33);
      finish = 1'b0;
      check_drained("drain_game3");

      // Reset mid-SHOW, then a restart replays the post-reset card sequence
      do_reset();
      wait_cyc(s);
      start = 1'b1;
      push(EV_SHOW, s + 2, 1);
      push(EV_COUNT, s + 6, 2);
      push(EV_BLANK, 0, 0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 7);
      rst = 1'b0;
      @(negedge clk);
      check("midshow_rst_outputs", int'({c1, c2, n1, n2, count, card_valid, round, game_over}), 0);
      check("midshow_rst_lfsr", int'(dut.u_lfsr.q), 16'hACE1);
      @(negedge clk);
      rst = 1'b1;
      wait_cyc(s);
      start = 1'b1;
      push_timeout_round(s + 2, 1);
      push_timeout_round(s + 17, 2);
      push(EV_DONE, s + 31, 0);
      @(negedge clk);
      start = 1'b0;
      wait_cyc(s + 33);
      check_drained("drain_game4");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
